// File: rtl/dekatron_pkg.sv
// Shared encodings for the dekatron step sequencer: command ops, FSM states,
// digit width and the one-hot "zero" pattern a stage shows at rest.
package dekatron_pkg;

  localparam int DIGIT_W = 10;
  localparam logic [DIGIT_W-1:0] ONEHOT_ZERO = 10'b0000000001;

  typedef enum logic [1:0] {
    OP_COUNT = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // A stage about to wrap sits on 9 when counting up and on 0 when counting down.
  function automatic logic digit_carry(input logic [DIGIT_W-1:0] digit, input logic reverse);
    return reverse ? digit[0] : digit[DIGIT_W-1];
  endfunction

endpackage

// File: rtl/dekatron_pulse_timer.sv
// Loadable down-counter timing the Step high and low phases; tc flags the
// last cycle of the loaded duration.
module dekatron_pulse_timer #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == '0);

endmodule

// File: rtl/dekatron_step_sequencer.sv
// Drives a chain of one-hot decimal dekatron stages: unit count steps with
// carry/borrow ripple, and simultaneous parallel load / clear.
module dekatron_step_sequencer
  import dekatron_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic                      cmd_reverse,
  input  logic [CNT_W-1:0]          cmd_count,
  input  logic [DIGITS*DIGIT_W-1:0] cmd_value,
  input  logic [DIGITS*DIGIT_W-1:0] dek_out,
  output logic [DIGITS-1:0]         dek_step,
  output logic [DIGITS-1:0]         dek_enable,
  output logic                      dek_reverse,
  output logic                      dek_set,
  output logic [DIGITS*DIGIT_W-1:0] dek_in,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int T_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int T_W   = $clog2(T_MAX + 1);
  localparam logic [K_W-1:0] K_LAST   = K_W'(DIGITS - 1);
  localparam logic [T_W-1:0] PULSE_LD = T_W'(PULSE_W - 1);
  localparam logic [T_W-1:0] GAP_LD   = T_W'(GAP_W - 1);

  state_e              state_r;
  logic                is_load_r;
  logic                carry_r;
  logic [CNT_W-1:0]    count_r;
  logic [K_W-1:0]      k_r;

  logic                accept_s;
  logic                tmr_load_s;
  logic [T_W-1:0]      tmr_val_s;
  logic                tmr_tc_s;
  logic [DIGITS-1:0]   k_sel_s;
  logic [DIGITS-1:0]   k_next_sel_s;
  logic [DIGIT_W-1:0]  digit_s;

  assign accept_s     = cmd_valid & cmd_ready;
  assign k_sel_s      = DIGITS'(1'b1) << k_r;
  assign k_next_sel_s = DIGITS'(1'b1) << (k_r + K_W'(1'b1));
  assign digit_s      = dek_out[k_r*DIGIT_W +: DIGIT_W];

  // Timer is armed with the pulse length on SAMPLE and the gap length when the pulse ends.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = PULSE_LD;
    case (state_r)
      ST_SAMPLE: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = PULSE_LD;
      end
      ST_PULSE: begin
        if (tmr_tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end else begin
          tmr_load_s = 1'b0;
          tmr_val_s  = PULSE_LD;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_val_s  = PULSE_LD;
      end
    endcase
  end

  dekatron_pulse_timer #(
    .W (T_W)
  ) u_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Sequencer FSM with all stage controls and handshake outputs registered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      dek_step    <= '0;
      dek_enable  <= '0;
      dek_reverse <= 1'b0;
      dek_set     <= 1'b0;
      dek_in      <= '0;
      is_load_r   <= 1'b0;
      carry_r     <= 1'b0;
      count_r     <= '0;
      k_r         <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            overflow    <= 1'b0;
            dek_reverse <= cmd_reverse;
            count_r     <= cmd_count;
            k_r         <= '0;
            carry_r     <= 1'b0;
            case (op_e'(cmd_op))
              OP_LOAD: begin
                is_load_r  <= 1'b1;
                dek_set    <= 1'b1;
                dek_in     <= cmd_value;
                dek_enable <= {DIGITS{1'b1}};
                state_r    <= ST_SAMPLE;
              end
              OP_CLEAR: begin
                is_load_r  <= 1'b1;
                dek_set    <= 1'b1;
                dek_in     <= {DIGITS{ONEHOT_ZERO}};
                dek_enable <= {DIGITS{1'b1}};
                state_r    <= ST_SAMPLE;
              end
              OP_COUNT: begin
                is_load_r <= 1'b0;
                if (cmd_count == '0) begin
                  done       <= 1'b1;
                  dek_set    <= 1'b0;
                  dek_enable <= '0;
                  state_r    <= ST_DONE;
                end else begin
                  dek_enable <= DIGITS'(1'b1);
                  state_r    <= ST_SAMPLE;
                end
              end
              default: begin
                is_load_r  <= 1'b0;
                done       <= 1'b1;
                dek_set    <= 1'b0;
                dek_enable <= '0;
                state_r    <= ST_DONE;
              end
            endcase
          end
        end
        ST_SAMPLE: begin
          // Carry is fixed here; the stage is not looked at again until the next SAMPLE.
          dek_step <= is_load_r ? {DIGITS{1'b1}} : k_sel_s;
          carry_r  <= is_load_r ? 1'b0 : digit_carry(digit_s, dek_reverse);
          state_r  <= ST_PULSE;
        end
        ST_PULSE: begin
          if (tmr_tc_s) begin
            dek_step <= '0;
            state_r  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_tc_s) begin
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (is_load_r) begin
            done       <= 1'b1;
            dek_set    <= 1'b0;
            dek_enable <= '0;
            state_r    <= ST_DONE;
          end else if (carry_r && (k_r != K_LAST)) begin
            k_r        <= k_r + K_W'(1'b1);
            dek_enable <= k_next_sel_s;
            state_r    <= ST_SAMPLE;
          end else begin
            if (carry_r) begin
              overflow <= 1'b1;
            end
            if (count_r == CNT_W'(1'b1)) begin
              count_r    <= '0;
              done       <= 1'b1;
              dek_set    <= 1'b0;
              dek_enable <= '0;
              state_r    <= ST_DONE;
            end else begin
              count_r    <= count_r - CNT_W'(1'b1);
              k_r        <= '0;
              dek_enable <= DIGITS'(1'b1);
              state_r    <= ST_SAMPLE;
            end
          end
        end
        ST_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          dek_step   <= '0;
          dek_set    <= 1'b0;
          dek_enable <= '0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Self-checking bench: behavioural dekatron stages plus decimal-arithmetic
// expectations for counts, ripples, loads and handshake timing.
module tb_dekatron_step_sequencer;

  localparam int DIGITS  = 3;
  localparam int CNT_W   = 8;
  localparam int PULSE_W = 2;
  localparam int GAP_W   = 2;
  localparam int DW      = 10;

  logic                   Clk = 1'b0;
  logic                   Rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [1:0]             cmd_op = 2'b00;
  logic                   cmd_reverse = 1'b0;
  logic [CNT_W-1:0]       cmd_count = '0;
  logic [DIGITS*DW-1:0]   cmd_value = '0;
  logic [DIGITS*DW-1:0]   dek_out;
  logic [DIGITS-1:0]      dek_step;
  logic [DIGITS-1:0]      dek_enable;
  logic                   dek_reverse;
  logic                   dek_set;
  logic [DIGITS*DW-1:0]   dek_in;
  logic                   busy;
  logic                   done;
  logic                   overflow;

  always #5 Clk = ~Clk;

  dekatron_step_sequencer #(
    .DIGITS (DIGITS), .CNT_W (CNT_W), .PULSE_W (PULSE_W), .GAP_W (GAP_W)
  ) dut (
    .Clk (Clk), .Rst_n (Rst_n), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_op (cmd_op), .cmd_reverse (cmd_reverse), .cmd_count (cmd_count),
    .cmd_value (cmd_value), .dek_out (dek_out), .dek_step (dek_step),
    .dek_enable (dek_enable), .dek_reverse (dek_reverse), .dek_set (dek_set),
    .dek_in (dek_in), .busy (busy), .done (done), .overflow (overflow)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural stages: each moves one position (or loads) on a Step rising edge.
  int stage  [DIGITS] = '{default: 0};
  int pulses [DIGITS] = '{default: 0};
  int hi_len [DIGITS] = '{default: 0};
  int width_err = 0;
  logic [DIGITS-1:0] step_prev = '0;
  logic [DIGITS-1:0] ev_q[$];
  logic              set_q[$];

  function automatic int onehot_index(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int pow10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [DIGITS*DW-1:0] to_onehot(input int v);
    logic [DIGITS*DW-1:0] r = '0;
    logic [DW-1:0] one = 10'd1;
    for (int d = 0; d < DIGITS; d++) r[d*DW +: DW] = one << ((v / pow10(d)) % 10);
    return r;
  endfunction

  function automatic int stage_value();
    int r = 0;
    for (int d = 0; d < DIGITS; d++) r = r + stage[d] * pow10(d);
    return r;
  endfunction

  always_comb begin
    dek_out = '0;
    for (int d = 0; d < DIGITS; d++) dek_out[d*DW +: DW] = 10'd1 << stage[d];
  end

  always @(posedge Clk) begin
    for (int d = 0; d < DIGITS; d++) begin
      if (dek_step[d] && !step_prev[d]) begin
        if (dek_enable[d]) begin
          if (dek_set) stage[d] <= onehot_index(dek_in[d*DW +: DW]);
          else if (dek_reverse) stage[d] <= (stage[d] + 9) % 10;
          else stage[d] <= (stage[d] + 1) % 10;
          pulses[d] <= pulses[d] + 1;
        end
        hi_len[d] <= 1;
      end else if (dek_step[d]) begin
        hi_len[d] <= hi_len[d] + 1;
      end else if (step_prev[d] && hi_len[d] != PULSE_W) begin
        width_err <= width_err + 1;
      end
    end
    if ((dek_step & ~step_prev) != '0) begin
      ev_q.push_back(dek_step & ~step_prev);
      set_q.push_back(dek_set);
    end
    step_prev <= dek_step;
  end

  // Results of the last run_cmd call.
  int   r_lat, r_ndone;
  logic r_to, r_rev_and, r_set_done;
  logic [DIGITS-1:0] r_en_done;

  task automatic run_cmd(input logic [1:0] op, input logic rev, input logic [CNT_W-1:0] cnt,
                         input logic [DIGITS*DW-1:0] val);
    int guard = 0;
    @(negedge Clk);
    cmd_op = op; cmd_reverse = rev; cmd_count = cnt; cmd_value = val; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    @(negedge Clk);
    cmd_valid = 1'b0;
    r_lat = 0; r_ndone = 0; r_to = 1'b1; r_rev_and = 1'b1; r_set_done = 1'bx; r_en_done = 'x;
    for (int c = 1; c <= 20000; c++) begin
      r_rev_and = r_rev_and & dek_reverse;
      if (done === 1'b1) begin
        r_ndone++;
        if (r_lat == 0) begin
          r_lat = c; r_set_done = dek_set; r_en_done = dek_enable;
        end
      end
      if (r_lat != 0 && c > r_lat) begin
        r_to = 1'b0;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    tests++;
    if ({cmd_ready, busy, done, overflow} !== 4'b1000) begin
      fails++; $display("FAIL reset_status: got %b expected 1000", {cmd_ready, busy, done, overflow});
    end
    tests++;
    if ({dek_step, dek_enable, dek_reverse, dek_set} !== '0 || dek_in !== '0) begin
      fails++; $display("FAIL reset_stage_ctrl: step=%b en=%b rev=%b set=%b in=%h expected all 0",
                        dek_step, dek_enable, dek_reverse, dek_set, dek_in);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_pulse();
    int g = 0;
    run_cmd(2'b01, 1'b0, '0, to_onehot(999));
    @(negedge Clk);
    cmd_op = 2'b00; cmd_reverse = 1'b0; cmd_count = 8'd3; cmd_valid = 1'b1;
    @(negedge Clk);
    cmd_valid = 1'b0;
    while (!(overflow === 1'b1 && dek_step !== '0) && g < 200) begin
      @(negedge Clk);
      g++;
    end
    tests++;
    if (g >= 200) begin
      fails++; $display("FAIL midpulse_wait: got timeout after %0d cycles required overflow with step high", g);
    end
    #2 Rst_n = 1'b0;
    #1;
    tests++;
    if (dek_step !== '0) begin
      fails++; $display("FAIL midpulse_step_drop: got %b expected 000", dek_step);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    tests++;
    if ({cmd_ready, overflow, busy} !== 3'b100) begin
      fails++; $display("FAIL midpulse_release: got rdy/ovf/busy %b expected 100", {cmd_ready, overflow, busy});
    end
  endtask

  task automatic test_count_fwd();
    int p0 [DIGITS];
    int w0 = width_err;
    run_cmd(2'b10, 1'b0, '0, '0);
    tests++;
    if (stage_value() != 0) begin
      fails++; $display("FAIL clear_value: got %0d expected 0", stage_value());
    end
    for (int d = 0; d < DIGITS; d++) p0[d] = pulses[d];
    run_cmd(2'b00, 1'b0, 8'd12, '0);
    tests++;
    if (r_to !== 1'b0 || r_ndone != 1) begin
      fails++; $display("FAIL fwd12_done: got timeout=%b dones=%0d expected 0 and 1", r_to, r_ndone);
    end
    tests++;
    if (pulses[0]-p0[0] != 12 || pulses[1]-p0[1] != 1 || pulses[2]-p0[2] != 0) begin
      fails++; $display("FAIL fwd12_pulses: got %0d/%0d/%0d expected 12/1/0",
                        pulses[0]-p0[0], pulses[1]-p0[1], pulses[2]-p0[2]);
    end
    tests++;
    if (stage_value() != 12 || overflow !== 1'b0) begin
      fails++; $display("FAIL fwd12_result: got value %0d ovf %b expected 12 and 0", stage_value(), overflow);
    end
    tests++;
    if (width_err != w0) begin
      fails++; $display("FAIL fwd12_width: got %0d bad pulse widths expected 0", width_err - w0);
    end
  endtask

  task automatic test_ripple();
    int n0;
    run_cmd(2'b01, 1'b0, '0, to_onehot(999));
    n0 = ev_q.size();
    run_cmd(2'b00, 1'b0, 8'd1, '0);
    tests++;
    if (ev_q.size() != n0 + 3) begin
      fails++; $display("FAIL ripple_count: got %0d step events expected 3", ev_q.size() - n0);
    end else if (ev_q[n0] !== 3'b001 || ev_q[n0+1] !== 3'b010 || ev_q[n0+2] !== 3'b100) begin
      fails++; $display("FAIL ripple_order: got %b %b %b expected 001 010 100", ev_q[n0], ev_q[n0+1], ev_q[n0+2]);
    end
    tests++;
    if (stage_value() != 0 || overflow !== 1'b1) begin
      fails++; $display("FAIL ripple_result: got value %0d ovf %b expected 0 and 1", stage_value(), overflow);
    end
  endtask

  task automatic test_borrow();
    run_cmd(2'b01, 1'b0, '0, to_onehot(1));
    run_cmd(2'b00, 1'b1, 8'd2, '0);
    tests++;
    if (stage_value() != 999 || overflow !== 1'b1) begin
      fails++; $display("FAIL borrow_result: got value %0d ovf %b expected 999 and 1", stage_value(), overflow);
    end
    tests++;
    if (r_rev_and !== 1'b1) begin
      fails++; $display("FAIL borrow_reverse: got reverse low during command expected 1 throughout");
    end
  endtask

  task automatic test_load();
    int n0 = ev_q.size();
    run_cmd(2'b01, 1'b0, '0, to_onehot(735));
    tests++;
    if (ev_q.size() != n0 + 1) begin
      fails++; $display("FAIL load_events: got %0d step events expected 1", ev_q.size() - n0);
    end else if (ev_q[n0] !== 3'b111 || set_q[n0] !== 1'b1) begin
      fails++; $display("FAIL load_step: got mask %b set %b expected 111 and 1", ev_q[n0], set_q[n0]);
    end
    tests++;
    if (r_set_done !== 1'b0 || r_en_done !== 3'b000) begin
      fails++; $display("FAIL load_done_ctrl: got set %b en %b expected 0 and 000", r_set_done, r_en_done);
    end
    tests++;
    if (stage_value() != 735 || overflow !== 1'b0) begin
      fails++; $display("FAIL load_result: got value %0d ovf %b expected 735 and 0", stage_value(), overflow);
    end
  endtask

  task automatic test_back_to_back();
    int n0, g, lat;
    run_cmd(2'b01, 1'b0, '0, to_onehot(458));
    n0 = ev_q.size();
    @(negedge Clk);
    cmd_op = 2'b00; cmd_reverse = 1'b0; cmd_count = 8'd0; cmd_valid = 1'b1;
    @(negedge Clk);
    tests++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL zero_count_done: got done %b rdy %b expected 1 and 0", done, cmd_ready);
    end
    cmd_count = 8'd1;
    @(negedge Clk);
    tests++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL b2b_ready: got rdy %b done %b expected 1 and 0", cmd_ready, done);
    end
    tests++;
    if (ev_q.size() != n0) begin
      fails++; $display("FAIL zero_count_steps: got %0d step events expected 0", ev_q.size() - n0);
    end
    @(negedge Clk);
    cmd_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_accept: got busy %b rdy %b expected 1 and 0", busy, cmd_ready);
    end
    lat = 1; g = 0;
    while (done !== 1'b1 && g < 100) begin
      @(negedge Clk);
      lat++; g++;
    end
    tests++;
    if (lat != PULSE_W + GAP_W + 3) begin
      fails++; $display("FAIL unit_latency: got %0d cycles expected %0d", lat, PULSE_W + GAP_W + 3);
    end
    @(negedge Clk);
    tests++;
    if (stage_value() != 459 || ev_q.size() != n0 + 1 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_result: got value %0d events %0d rdy %b expected 459, 1, 1",
                        stage_value(), ev_q.size() - n0, cmd_ready);
    end
  endtask

  task automatic test_random();
    int p0 [DIGITS];
    int ep [DIGITS];
    int v, n, ev, sel, m;
    logic rev, eovf;
    logic [1:0] op;
    for (int it = 0; it < 20; it++) begin
      v = stage_value();
      sel = $urandom_range(0, 9);
      rev = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 120);
      op = (sel == 6) ? 2'b01 : (sel == 7) ? 2'b10 : (sel == 8) ? 2'b11 : 2'b00;
      if (op == 2'b11) n = 0;
      m = $urandom_range(0, 999);
      if (op == 2'b01) begin
        ev = m; eovf = 1'b0;
        for (int d = 0; d < DIGITS; d++) ep[d] = 1;
      end else if (op == 2'b10) begin
        ev = 0; eovf = 1'b0;
        for (int d = 0; d < DIGITS; d++) ep[d] = 1;
      end else begin
        ev = rev ? (((v - n) % 1000) + 1000) % 1000 : (v + n) % 1000;
        eovf = rev ? ((999 - v + n) / 1000 > 0) : ((v + n) / 1000 > 0);
        for (int d = 0; d < DIGITS; d++) begin
          if (d == 0) ep[d] = n;
          else ep[d] = rev ? (pow10(d) - 1 - v % pow10(d) + n) / pow10(d) : (v % pow10(d) + n) / pow10(d);
        end
      end
      for (int d = 0; d < DIGITS; d++) p0[d] = pulses[d];
      run_cmd(op, rev, CNT_W'(n), to_onehot(m));
      tests++;
      if (r_to !== 1'b0 || r_ndone != 1) begin
        fails++; $display("FAIL rnd%0d_done: got timeout=%b dones=%0d expected 0 and 1", it, r_to, r_ndone);
      end
      tests++;
      if (stage_value() != ev || overflow !== eovf) begin
        fails++; $display("FAIL rnd%0d_result: op %0d rev %b n %0d from %0d got %0d ovf %b expected %0d ovf %b",
                          it, op, rev, n, v, stage_value(), overflow, ev, eovf);
      end
      tests++;
      if (pulses[0]-p0[0] != ep[0] || pulses[1]-p0[1] != ep[1] || pulses[2]-p0[2] != ep[2]) begin
        fails++; $display("FAIL rnd%0d_pulses: got %0d/%0d/%0d expected %0d/%0d/%0d", it,
                          pulses[0]-p0[0], pulses[1]-p0[1], pulses[2]-p0[2], ep[0], ep[1], ep[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_pulse();
    test_count_fwd();
    test_ripple();
    test_borrow();
    test_load();
    test_back_to_back();
    test_random();
    tests++;
    if (width_err != 0) begin
      fails++; $display("FAIL pulse_width: got %0d pulses not %0d cycles wide expected 0", width_err, PULSE_W);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
